// File: rtl/axis_len_header_gen_if.sv
// AXI-Stream bundle shared by the input and output sides of the length/header generator.
// Ports: tdata/tkeep/tdest/tuser/tlast/tvalid flow from master to slave, tready flows back.
// master drives the beat, slave drives tready.
interface axis_len_header_gen_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [STRB_WIDTH-1:0] tkeep;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tdest, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tdest, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_len_header_gen.sv
// Purpose: store-and-forward packet buffer that counts bytes and emits a length/dest/user/seq header.
// Latency: first beat of a packet appears on m_axis one cycle after its tlast is accepted.
// Backpressure: s_axis stalls when the data FIFO is full or a tlast finds the header FIFO full.
// Ports: clk, rst_n (async active-low); s_axis (slave stream in); m_axis (master stream out);
//        header/header_valid/header_ready (one header per packet, valid with its first beat);
//        drop_pulse (one cycle per packet discarded for exceeding the buffer).
module axis_len_header_gen #(
    parameter int DATA_WIDTH = 128,
    parameter int HDR_WIDTH  = 64,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 64,
    parameter int HDR_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_len_header_gen_if.slave     s_axis,
    axis_len_header_gen_if.master    m_axis,
    output logic [HDR_WIDTH-1:0]     header,
    output logic                     header_valid,
    input  logic                     header_ready,
    output logic                     drop_pulse
);
    localparam int AW     = $clog2(DEPTH);
    localparam int HAW    = $clog2(HDR_DEPTH);
    localparam int WORD_W = DATA_WIDTH + STRB_WIDTH + 1 + DEST_WIDTH + USER_WIDTH;
    localparam logic [AW:0]  DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]  PONE     = (AW+1)'(1);
    localparam logic [HAW:0] HDEPTH_W = (HAW+1)'(HDR_DEPTH);
    localparam logic [HAW:0] HONE     = (HAW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [AW:0]           wr_spec_q, wr_spec_d;   // speculative write pointer (in-progress packet)
    logic [AW:0]           wr_cmt_q, wr_cmt_d;     // end of the last complete packet
    logic [AW:0]           rd_q, rd_d;
    logic [AW:0]           pkt_cnt_q, pkt_cnt_d;   // complete packets waiting to be read
    logic [AW:0]           words_q, words_d;       // words held by the in-progress packet
    logic [15:0]           bytes_q, bytes_d;
    logic [15:0]           seq_q, seq_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  out_first_q, out_first_d;
    logic [HAW:0]          hwr_q, hwr_d, hrd_q, hrd_d;

    logic [WORD_W-1:0]     mem_q  [DEPTH];
    logic [HDR_WIDTH-1:0]  hmem_q [HDR_DEPTH];

    logic                  data_full, hdr_empty, hdr_full, hdr_pop, hdr_push;
    logic                  s_acc, wr_en, m_hs, m_last_hs;
    logic [15:0]           beat_bytes, len_sat;
    logic [16:0]           byte_sum;
    logic [DEST_WIDTH-1:0] cur_dest;
    logic [USER_WIDTH-1:0] cur_user;
    logic [HDR_WIDTH-1:0]  hdr_word;

    assign data_full    = (wr_spec_q - rd_q) == DEPTH_W;
    assign hdr_empty    = (hwr_q == hrd_q);
    assign hdr_full     = (hwr_q - hrd_q) == HDEPTH_W;
    assign header_valid = out_first_q && !hdr_empty;
    assign hdr_pop      = header_valid && header_ready;
    assign header       = hmem_q[hrd_q[HAW-1:0]];

    // A tlast may enter a full header FIFO when a pop frees a slot in the same cycle.
    assign s_axis.tready = rst_n && ((state_q == S_DROP) ||
                           (!data_full && !(s_axis.tlast && hdr_full && !hdr_pop)));
    assign s_acc    = s_axis.tvalid && s_axis.tready;
    assign wr_en    = s_acc && (state_q != S_DROP);
    assign hdr_push = wr_en && s_axis.tlast;

    // The first beat supplies dest/user directly; later beats reuse the latched copy.
    assign cur_dest = (state_q == S_IDLE) ? s_axis.tdest : dest_q;
    assign cur_user = (state_q == S_IDLE) ? s_axis.tuser : user_q;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            beat_bytes = beat_bytes + 16'(s_axis.tkeep[i]);
        end
    end
    assign byte_sum = {1'b0, bytes_q} + {1'b0, beat_bytes};
    assign len_sat  = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    always_comb begin
        hdr_word        = '0;
        hdr_word[47:0]  = {seq_q, 8'(cur_user), 8'(cur_dest), len_sat};
    end

    assign m_axis.tvalid = (pkt_cnt_q != '0);
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tdest, m_axis.tuser} =
           mem_q[rd_q[AW-1:0]];
    assign m_hs      = m_axis.tvalid && m_axis.tready;
    assign m_last_hs = m_hs && m_axis.tlast;

    always_comb begin
        state_d     = state_q;
        wr_spec_d   = wr_spec_q;
        wr_cmt_d    = wr_cmt_q;
        rd_d        = rd_q;
        words_d     = words_q;
        bytes_d     = bytes_q;
        seq_d       = seq_q;
        dest_d      = dest_q;
        user_d      = user_q;
        out_first_d = out_first_q;
        hwr_d       = hwr_q;
        hrd_d       = hrd_q;
        drop_pulse  = 1'b0;

        case (state_q)
            S_IDLE: if (s_acc && !s_axis.tlast) state_d = S_BODY;
            S_BODY: begin
                // Buffer is exhausted by this packet alone: any further beat means it cannot
                // fit, including a final tlast beat (which would otherwise never be accepted).
                if (words_q == DEPTH_W && s_axis.tvalid) state_d = S_DROP;
                else if (s_acc && s_axis.tlast)         state_d = S_IDLE;
            end
            S_DROP: begin
                if (s_acc && s_axis.tlast) begin
                    state_d    = S_IDLE;
                    drop_pulse = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            wr_spec_d = wr_spec_q + PONE;
            words_d   = words_q + PONE;
            bytes_d   = len_sat;
            if (state_q == S_IDLE) begin
                dest_d = s_axis.tdest;
                user_d = s_axis.tuser;
            end
            if (s_axis.tlast) begin
                wr_cmt_d = wr_spec_q + PONE;
                words_d  = '0;
                bytes_d  = '0;
                seq_d    = seq_q + 16'd1;
                hwr_d    = hwr_q + HONE;
            end
        end

        // Throw away the partial packet so its words never become readable.
        if (state_q == S_DROP) begin
            wr_spec_d = wr_cmt_q;
            words_d   = '0;
            bytes_d   = '0;
        end

        if (m_hs) begin
            rd_d        = rd_q + PONE;
            out_first_d = m_axis.tlast;
        end
        if (hdr_pop) hrd_d = hrd_q + HONE;
    end

    assign pkt_cnt_d = pkt_cnt_q + (AW+1)'(hdr_push) - (AW+1)'(m_last_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_spec_q   <= '0;
            wr_cmt_q    <= '0;
            rd_q        <= '0;
            pkt_cnt_q   <= '0;
            words_q     <= '0;
            bytes_q     <= '0;
            seq_q       <= '0;
            dest_q      <= '0;
            user_q      <= '0;
            out_first_q <= 1'b1;
            hwr_q       <= '0;
            hrd_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_spec_q   <= wr_spec_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_q        <= rd_d;
            pkt_cnt_q   <= pkt_cnt_d;
            words_q     <= words_d;
            bytes_q     <= bytes_d;
            seq_q       <= seq_d;
            dest_q      <= dest_d;
            user_q      <= user_d;
            out_first_q <= out_first_d;
            hwr_q       <= hwr_d;
            hrd_q       <= hrd_d;
        end
    end

    // Storage arrays carry no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_spec_q[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast, cur_dest, cur_user};
        end
        if (hdr_push) begin
            hmem_q[hwr_q[HAW-1:0]] <= hdr_word;
        end
    end
endmodule

// File: tb/tb_axis_len_header_gen.sv
module tb_axis_len_header_gen;
    localparam int DW = 128, HW = 64, SW = 16, DEPTH = 64, HDEPTH = 8;
    localparam int BOUND = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_len_header_gen_if #(.DATA_WIDTH(DW), .DEST_WIDTH(8), .USER_WIDTH(8)) s_if ();
    axis_len_header_gen_if #(.DATA_WIDTH(DW), .DEST_WIDTH(8), .USER_WIDTH(8)) m_if ();
    logic [HW-1:0] header;
    logic          header_valid;
    logic          header_ready = 1'b0;
    logic          drop_pulse;

    axis_len_header_gen #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .DEST_WIDTH(8), .USER_WIDTH(8),
                          .DEPTH(DEPTH), .HDR_DEPTH(HDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
        .header(header), .header_valid(header_valid), .header_ready(header_ready),
        .drop_pulse(drop_pulse));

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] keep;
        logic          last;
        logic [7:0]    dest;
        logic [7:0]    user;
    } beat_t;

    typedef struct {
        int          nb;
        int          last_n;
        logic [7:0]  d;
        logic [7:0]  u;
        logic [63:0] exp;
    } vec_t;

    beat_t         exp_beats[$];
    logic [HW-1:0] exp_hdrs[$];
    int            n_cmp = 0, n_bad = 0;
    int            seq_m = 0;
    bit            lat_chk = 1'b0;
    bit            last_drop;
    logic [HW-1:0] h;
    vec_t          tbl[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [SW-1:0] keep_of(input int n);
        logic [SW-1:0] k = '0;
        for (int i = 0; i < SW; i++) if (i < n) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [HW-1:0] mk_hdr(input int len, input int seq, input logic [7:0] d, input logic [7:0] u);
        logic [HW-1:0] r = '0;
        r[15:0]  = (len > 65535) ? 16'hFFFF : 16'(len);
        r[23:16] = d;
        r[31:24] = u;
        r[47:32] = 16'(seq);
        return r;
    endfunction

    task automatic send_beat(input beat_t b, output bit ok);
        int c = 0;
        ok = 1'b0;
        @(negedge clk);
        s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tlast = b.last;
        s_if.tdest = b.dest; s_if.tuser = b.user; s_if.tvalid = 1'b1;
        while (!ok && c < BOUND) begin
            #1;
            if (s_if.tready) begin
                last_drop = drop_pulse;
                if (b.last && lat_chk) chk("lat_before_commit", 256'({header_valid, m_if.tvalid}), 256'(0));
                ok = 1'b1;
                @(posedge clk);
            end else begin
                c++;
                @(negedge clk);
            end
        end
        if (!ok) fail("send_beat");
    endtask

    task automatic idle();
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Model: a committed packet contributes its beats in order and one header whose length is
    // the sum of enabled bytes and whose sequence number counts committed packets.
    task automatic send_pkt(input int nb, input int last_n, input bit rnd_keep, input logic [7:0] d, input logic [7:0] u);
        beat_t pkt[$];
        beat_t b;
        int    len = 0;
        bit    ok, all_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.last = (i == nb - 1);
            if (b.last && last_n >= 0) b.keep = keep_of(last_n);
            else if (rnd_keep)         b.keep = keep_of(int'($urandom_range(0, 16)));
            else                       b.keep = keep_of(16);
            b.dest = d;
            b.user = u;
            for (int k = 0; k < SW; k++) len += int'(b.keep[k]);
            send_beat(b, ok);
            all_ok &= ok;
            pkt.push_back(b);
        end
        if (all_ok) begin
            foreach (pkt[i]) exp_beats.push_back(pkt[i]);
            exp_hdrs.push_back(mk_hdr(len, seq_m, d, u));
            seq_m++;
        end
    endtask

    task automatic recv_pkt(input bit rnd, input bit hdr_done, output logic [HW-1:0] got_hdr);
        bit    done = 1'b0, taken = hdr_done;
        int    c = 0;
        beat_t got;
        got_hdr = '0;
        while (!done && c < BOUND) begin
            @(negedge clk);
            m_if.tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            header_ready = !taken;
            if (header_valid && header_ready) begin
                got_hdr = header;
                taken   = 1'b1;
                if (exp_hdrs.size() != 0) chk("hdr", 256'(header), 256'(exp_hdrs.pop_front()));
                else fail("hdr_unexpected");
            end
            if (m_if.tvalid && m_if.tready) begin
                got = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tdest, m_if.tuser};
                if (exp_beats.size() != 0) chk("beat", 256'(got), 256'(exp_beats.pop_front()));
                else fail("beat_unexpected");
                if (got.last) done = 1'b1;
            end
            c++;
        end
        if (!done) fail("recv_pkt");
        chk("hdr_taken", 256'(taken), 256'(1));
        @(posedge clk);
        #1;
        header_ready = 1'b0;
        m_if.tready  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0; header_ready = 1'b0;
        exp_beats.delete(); exp_hdrs.delete(); seq_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        bit    ok;
        int    drops, drop_at;

        tbl[0] = '{1, 8, 8'h03, 8'h5A, 64'h0000_0000_5A03_0008};
        tbl[1] = '{3, 12, 8'h03, 8'h5A, 64'h0000_0001_5A03_002C};
        tbl[2] = '{1, 0, 8'hFF, 8'h00, 64'h0000_0002_00FF_0000};
        tbl[3] = '{2, 1, 8'h00, 8'hFF, 64'h0000_0003_FF00_0011};
        tbl[4] = '{4, 15, 8'h80, 8'h01, 64'h0000_0004_0180_003F};
        tbl[5] = '{DEPTH, 16, 8'h42, 8'h24, 64'h0000_0005_2442_0400};

        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
        s_if.tdest = '0; s_if.tuser = '0; m_if.tready = 1'b0;

        // Reset state
        #1;
        chk("rst_s_tready", 256'(s_if.tready), 256'(0));
        chk("rst_m_tvalid", 256'(m_if.tvalid), 256'(0));
        chk("rst_hdr_valid", 256'(header_valid), 256'(0));
        chk("rst_drop", 256'(drop_pulse), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_s_tready", 256'(s_if.tready), 256'(1));

        // Table-driven single packets with output held off until commit
        foreach (tbl[i]) begin
            chk("tbl_pre_idle", 256'({header_valid, m_if.tvalid}), 256'(0));
            lat_chk = 1'b1;
            send_pkt(tbl[i].nb, tbl[i].last_n, 1'b0, tbl[i].d, tbl[i].u);
            lat_chk = 1'b0;
            idle();
            #1 chk("tbl_visible_next_cycle", 256'({header_valid, m_if.tvalid}), 256'(3));
            recv_pkt(1'b0, 1'b0, h);
            chk("tbl_hdr_const", 256'(h), 256'(tbl[i].exp));
        end

        // Random traffic with random output backpressure
        do_reset();
        fork
            begin
                for (int p = 0; p < 100; p++) begin
                    send_pkt(int'($urandom_range(1, 20)), -1, 1'b1, 8'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
            end
            begin
                for (int p = 0; p < 100; p++) begin
                    recv_pkt(1'b1, 1'b0, h);
                    chk("rnd_seq", 256'(h[47:32]), 256'(p));
                end
            end
        join
        chk("rnd_beats_left", 256'(exp_beats.size()), 256'(0));
        chk("rnd_hdrs_left", 256'(exp_hdrs.size()), 256'(0));
        #1 chk("rnd_drained", 256'({header_valid, m_if.tvalid}), 256'(0));

        // Oversized packet is dropped whole; the following packet is untouched
        do_reset();
        drops = 0; drop_at = 0;
        for (int i = 1; i <= 70; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = keep_of(16); b.last = (i == 70); b.dest = 8'h11; b.user = 8'h22;
            send_beat(b, ok);
            if (ok && last_drop) begin drops++; drop_at = i; end
        end
        idle();
        chk("drop_count", 256'(drops), 256'(1));
        chk("drop_beat", 256'(drop_at), 256'(70));
        repeat (3) @(negedge clk);
        #1 chk("drop_no_output", 256'({header_valid, m_if.tvalid}), 256'(0));
        send_pkt(2, 5, 1'b0, 8'h07, 8'h09);
        idle();
        recv_pkt(1'b0, 1'b0, h);
        chk("drop_next_hdr", 256'(h), 256'(64'h0000_0000_0907_0015));

        // Header FIFO full holds the next tlast until a header is popped
        do_reset();
        for (int i = 0; i < HDEPTH; i++) send_pkt(1, 4, 1'b0, 8'(i), 8'hA0);
        @(negedge clk);
        b.data = {$urandom, $urandom, $urandom, $urandom};
        b.keep = keep_of(3); b.last = 1'b1; b.dest = 8'h08; b.user = 8'hA0;
        s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tlast = 1'b1;
        s_if.tdest = b.dest; s_if.tuser = b.user; s_if.tvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("hfull_stall", 256'(s_if.tready), 256'(0));
            @(negedge clk);
        end
        header_ready = 1'b1;
        #1;
        chk("hfull_release", 256'(s_if.tready), 256'(1));
        chk("hfull_pop_hdr", 256'(header), 256'(exp_hdrs.pop_front()));
        @(posedge clk);
        #1 header_ready = 1'b0;
        exp_beats.push_back(b);
        exp_hdrs.push_back(mk_hdr(3, seq_m, 8'h08, 8'hA0));
        seq_m++;
        idle();
        recv_pkt(1'b0, 1'b1, h);
        for (int i = 1; i <= HDEPTH; i++) recv_pkt(1'b0, 1'b0, h);
        chk("hfull_last_seq", 256'(h[47:32]), 256'(8));

        // Asynchronous reset in the middle of a packet with packets buffered
        do_reset();
        send_pkt(1, 16, 1'b0, 8'h01, 8'h01);
        send_pkt(2, 16, 1'b0, 8'h02, 8'h02);
        for (int i = 0; i < 2; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = keep_of(16); b.last = 1'b0; b.dest = 8'h33; b.user = 8'h44;
            send_beat(b, ok);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        chk("arst_m_tvalid", 256'(m_if.tvalid), 256'(0));
        chk("arst_hdr_valid", 256'(header_valid), 256'(0));
        chk("arst_s_tready", 256'(s_if.tready), 256'(0));
        chk("arst_drop", 256'(drop_pulse), 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_beats.delete(); exp_hdrs.delete(); seq_m = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("arst_no_stale", 256'({header_valid, m_if.tvalid}), 256'(0));
        end
        send_pkt(1, 6, 1'b0, 8'h55, 8'h66);
        idle();
        recv_pkt(1'b0, 1'b0, h);
        chk("arst_seq0_hdr", 256'(h), 256'(64'h0000_0000_6655_0006));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
